// File: rtl/op_share_pkg.sv
// Shared types and the compute function for the op-share arbiter.
// Operand fields are sized to OP_W_MAX so one struct type serves every WIDTH
// up to that limit; narrower operands are zero-extended into it.
package op_share_pkg;

   localparam int unsigned OP_WIDTH_DEF = 2;
   localparam int unsigned OP_W_MAX     = 16;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef struct packed {
      op_e                 op;
      logic [OP_W_MAX-1:0] a;
      logic [OP_W_MAX-1:0] b;
   } op_req_t;

   // Zero-extended operands keep upper bits clear, so the caller can truncate
   // the result to WIDTH+1 bits with no loss (ADD carry included).
   function automatic logic [OP_W_MAX:0] op_compute(input op_req_t r);
      logic [OP_W_MAX:0] ea;
      logic [OP_W_MAX:0] eb;
      ea = {1'b0, r.a};
      eb = {1'b0, r.b};
      case (r.op)
         OP_AND:  return ea & eb;
         OP_OR:   return ea | eb;
         OP_XOR:  return ea ^ eb;
         default: return ea + eb;
      endcase
   endfunction

endpackage

// File: rtl/op_share_arbiter_if.sv
// Requester/consumer bus for op_share_arbiter.
// master: the client side; slave: the arbiter.
interface op_share_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned WIDTH   = 2
);
   localparam int unsigned IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [2*NUM_REQ-1:0]     opcode;
   logic [WIDTH*NUM_REQ-1:0] op_a;
   logic [WIDTH*NUM_REQ-1:0] op_b;
   logic [NUM_REQ-1:0]       gnt;
   logic                     res_valid;
   logic                     res_ready;
   logic [WIDTH:0]           res_data;
   logic [IDW-1:0]           res_id;
   logic                     busy;

   modport master (
      output req, opcode, op_a, op_b, res_ready,
      input  gnt, res_valid, res_data, res_id, busy
   );

   modport slave (
      input  req, opcode, op_a, op_b, res_ready,
      output gnt, res_valid, res_data, res_id, busy
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from i_last+1, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_last,
   output logic [NUM_REQ-1:0] o_pick,
   output logic [IDW-1:0]     o_idx,
   output logic               o_any
);

   int unsigned w_cand;

   // Scan candidates in priority order; the first hit wins.
   always_comb begin
      o_pick = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_cand = (32'(i_last) + k) % NUM_REQ;
         if (!o_any && i_req[w_cand]) begin
            o_any          = 1'b1;
            o_idx          = IDW'(w_cand);
            o_pick[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/op_share_arbiter.sv
// Round-robin arbiter/sequencer for one shared logic/add unit.
// IDLE grants and latches operands, EXEC computes, RESP holds the result
// until the consumer takes it. WIDTH must not exceed OP_W_MAX.
// Optional: OP_SHARE_ARB_STATS_EN adds per-requester saturating grant counters.
module op_share_arbiter
   import op_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned WIDTH   = OP_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   op_share_arbiter_if.slave    bus
`ifdef OP_SHARE_ARB_STATS_EN
   ,
   input  logic                 stats_clr,
   output logic [8*NUM_REQ-1:0] grant_cnt
`endif
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned RW  = WIDTH + 1;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_EXEC = EXEC;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]         r_state;
   logic [IDW-1:0]     r_last;
   logic [IDW-1:0]     r_idx;
   op_req_t            r_op;
   logic [WIDTH:0]     r_res_data;
   logic [IDW-1:0]     r_res_id;
   logic               r_res_valid;

   logic [NUM_REQ-1:0] w_pick;
   logic [IDW-1:0]     w_idx;
   logic               w_any;
   op_req_t            w_op_nxt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .i_req  (bus.req),
      .i_last (r_last),
      .o_pick (w_pick),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // Gather the winner's opcode and operands into the struct to be latched.
   always_comb begin
      w_op_nxt    = '0;
      w_op_nxt.op = op_e'(bus.opcode[2*w_idx +: 2]);
      w_op_nxt.a  = OP_W_MAX'(bus.op_a[WIDTH*w_idx +: WIDTH]);
      w_op_nxt.b  = OP_W_MAX'(bus.op_b[WIDTH*w_idx +: WIDTH]);
   end

   assign bus.gnt       = (r_state == ST_IDLE && !rst) ? w_pick : '0;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_id    = r_res_id;

   // Sequencer: one operation in flight, pointer advances on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_last      <= IDW'(NUM_REQ - 1);
         r_idx       <= '0;
         r_op        <= '0;
         r_res_data  <= '0;
         r_res_id    <= '0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_op    <= w_op_nxt;
                  r_idx   <= w_idx;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_res_data  <= RW'(op_compute(r_op));
               r_res_id    <= r_idx;
               r_res_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_last      <= r_res_id;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef OP_SHARE_ARB_STATS_EN
   logic [7:0] r_cnt [NUM_REQ];

   // Saturating per-requester grant counters; clear beats increment.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rst || stats_clr) begin
            r_cnt[i] <= '0;
         end else if (bus.gnt[i] && r_cnt[i] != 8'hFF) begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
         end
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         grant_cnt[8*i +: 8] = r_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_op_share_arbiter.sv
// Self-checking bench for op_share_arbiter: directed cases plus a randomized
// run against a transaction-level reference (pointer + arithmetic result).
module tb_op_share_arbiter;

   localparam int unsigned N = 3;
   localparam int unsigned W = 2;

   logic clk = 1'b0;
   logic rst;
`ifdef OP_SHARE_ARB_STATS_EN
   logic           stats_clr;
   logic [8*N-1:0] grant_cnt;
`endif

   op_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   op_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave)
`ifdef OP_SHARE_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_winner(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= int'(N); k++) begin
         int c;
         c = (last + k) % int'(N);
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic int ref_result(input int op, input int a, input int b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         default: return a + b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input int op, input int a, input int b);
      bus.opcode[2*i +: 2] = 2'(op);
      bus.op_a[W*i +: W]   = W'(a);
      bus.op_b[W*i +: W]   = W'(b);
   endtask

   task automatic rand_inputs();
      bus.req    = N'($urandom);
      bus.opcode = (2*N)'($urandom);
      bus.op_a   = (W*N)'($urandom);
      bus.op_b   = (W*N)'($urandom);
   endtask

   task automatic zero_inputs();
      bus.req       = '0;
      bus.opcode    = '0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b0;
`ifdef OP_SHARE_ARB_STATS_EN
      stats_clr     = 1'b0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Called right after a gnt-cycle check: drain EXEC and RESP back to IDLE.
   task automatic finish_op();
      tick();
      bus.req = '0;
      tick();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m_last, w, exp_res, stall;

      // Reset values
      rst = 1'b1;
      zero_inputs();
      tick();
      tick();
      @(negedge clk);
      chk("rst_gnt",   bus.gnt,       0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_data",  bus.res_data,  0);
      chk("rst_id",    bus.res_id,    0);
      chk("rst_busy",  bus.busy,      0);
      tick();
      rst = 1'b0;

      // ADD with carry from requester 0
      bus.req = 3'b001;
      set_slot(0, 3, 3, 1);
      @(negedge clk);
      chk("d1_gnt", bus.gnt, 3'b001);
      tick();
      bus.req = '0;
      @(negedge clk);
      chk("d1_exec_gnt",   bus.gnt,       0);
      chk("d1_exec_valid", bus.res_valid, 0);
      chk("d1_exec_busy",  bus.busy,      1);
      tick();
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("d1_valid", bus.res_valid, 1);
      chk("d1_data",  bus.res_data,  3'b100);
      chk("d1_id",    bus.res_id,    0);
      tick();
      bus.res_ready = 1'b0;

      // All requesting, ready tied high: 0,1,2,0,1,2 every 3 cycles
      do_reset();
      bus.req       = 3'b111;
      bus.op_a      = (W*N)'($urandom);
      bus.op_b      = (W*N)'($urandom);
      bus.res_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         chk("d2_gnt", bus.gnt, (c % 3 == 0) ? (1 << ((c / 3) % 3)) : 0);
         if (c % 3 == 2) chk("d2_id", bus.res_id, (c / 3) % 3);
         tick();
      end
      zero_inputs();

      // Backpressure in RESP with requester 1 pending
      bus.req = 3'b001;
      set_slot(0, 1, 1, 2);
      @(negedge clk);
      chk("d3_gnt0", bus.gnt, 3'b001);
      tick();
      bus.req = 3'b010;
      @(negedge clk);
      chk("d3_exec_gnt", bus.gnt, 0);
      tick();
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("d3_stall_valid", bus.res_valid, 1);
         chk("d3_stall_data",  bus.res_data,  3'b011);
         chk("d3_stall_id",    bus.res_id,    0);
         chk("d3_stall_gnt",   bus.gnt,       0);
         tick();
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("d3_hs_valid", bus.res_valid, 1);
      tick();
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("d3_gnt1", bus.gnt, 3'b010);
      finish_op();

      // Operands change after grant: latched copy is used
      bus.req = 3'b010;
      set_slot(1, 2, 2, 3);
      @(negedge clk);
      chk("d4_gnt", bus.gnt, 3'b010);
      tick();
      set_slot(1, 0, 0, 0);
      bus.req = '0;
      tick();
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("d4_data", bus.res_data, 3'b001);
      chk("d4_id",   bus.res_id,   1);
      tick();
      bus.res_ready = 1'b0;

      // Reset during EXEC aborts and restores the pointer
      bus.req = 3'b100;
      @(negedge clk);
      chk("d5_gnt2", bus.gnt, 3'b100);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("d5_exec_busy", bus.busy, 1);
      tick();
      rst = 1'b0;
      bus.req = 3'b111;
      @(negedge clk);
      chk("d5_valid", bus.res_valid, 0);
      chk("d5_busy",  bus.busy,      0);
      chk("d5_gnt",   bus.gnt,       3'b001);
      finish_op();

      // Randomized operations against the reference
      do_reset();
      m_last = N - 1;
      for (int op = 0; op < 80; op++) begin
         rand_inputs();
         bus.res_ready = 1'($urandom);
         @(negedge clk);
         w = ref_winner(bus.req, m_last);
         if (w < 0) begin
            chk("r_idle_gnt",  bus.gnt,  0);
            chk("r_idle_busy", bus.busy, 0);
            tick();
            continue;
         end
         exp_res = ref_result(int'(bus.opcode[2*w +: 2]), int'(bus.op_a[W*w +: W]),
                              int'(bus.op_b[W*w +: W]));
         chk("r_gnt", bus.gnt, 1 << w);
         tick();
         rand_inputs();
         bus.res_ready = 1'($urandom);
         @(negedge clk);
         chk("r_exec_gnt",   bus.gnt,       0);
         chk("r_exec_busy",  bus.busy,      1);
         chk("r_exec_valid", bus.res_valid, 0);
         tick();
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            bus.res_ready = (s == stall);
            rand_inputs();
            @(negedge clk);
            chk("r_valid", bus.res_valid, 1);
            chk("r_data",  bus.res_data,  exp_res);
            chk("r_id",    bus.res_id,    w);
            chk("r_gnt0",  bus.gnt,       0);
            tick();
         end
         m_last = w;
      end
      zero_inputs();

`ifdef OP_SHARE_ARB_STATS_EN
      // Counter saturation and clear-over-increment
      do_reset();
      bus.req       = 3'b001;
      bus.res_ready = 1'b1;
      repeat (900) tick();
      stats_clr = 1'b1;
      @(negedge clk);
      chk("s_gnt", bus.gnt, 3'b001);
      chk("s_sat", grant_cnt[7:0], 255);
      tick();
      stats_clr = 1'b0;
      @(negedge clk);
      chk("s_clr", grant_cnt[7:0], 0);
      zero_inputs();
      repeat (3) tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/op_share_arbiter.md
Name: op_share_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared 2-bit logic/add unit, used by up to NUM_REQ requesters. NUM_REQ defaults to 3, one requester per enum slot x, y, z.
- Latches the winner's operand pair into an operand struct, computes the result in one cycle, and returns it over a valid/ready handshake tagged with the requester index.
- Sits between the small-datapath clients and the shared AND/add resource, replacing per-client duplicated units.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 2, operand width in bits.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until its gnt bit pulses.
- opcode  in  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i].
- op_a  in  WIDTH*NUM_REQ  per-requester operand A, slice i.
- op_b  in  WIDTH*NUM_REQ  per-requester operand B, slice i.
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH+1  result.
- res_id  out  $clog2(NUM_REQ)  index of the requester that owns res_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: gnt=0, res_valid=0, res_data=0, res_id=0, busy=0, FSM=IDLE, rr pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req!=0, pick the first set bit searching upward from last+1, wrapping modulo NUM_REQ.
  - Assert gnt for that bit for exactly this cycle.
  - Latch opcode, op_a, op_b and the index into the operand struct register.
  - Next state EXEC.
  - If req==0, stay in IDLE.
- EXEC: compute res_data from the latched struct into the output register, set res_id, then go to RESP.
- Opcodes:
  - 00 AND, 01 OR, 10 XOR: result zero-extended to WIDTH+1.
  - 11 ADD: full WIDTH+1-bit sum including carry; no wrap, no saturation.
- RESP:
  - res_valid=1; res_data and res_id stay stable until res_ready.
  - On res_valid&&res_ready: res_valid clears next cycle, last<=res_id, next state IDLE.
- Latency and throughput: gnt cycle to res_valid is 2 cycles; minimum 3 cycles per operation with res_ready tied high.
- Only one operation is in flight; no new gnt is issued in EXEC or RESP.
- Requesters may change req and operands freely after their gnt pulse; the latched copy is used.
- A req deasserted before its grant is simply skipped; no error.
- Fairness: a requester that holds req waits at most NUM_REQ-1 other operations.
- res_ready asserted outside RESP is ignored.
- rst in any state aborts the operation: any in-flight result is discarded and all outputs and the pointer take their reset values on the next edge.

Optional Feature:
- Macro OP_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (8*NUM_REQ bits): one 8-bit saturating counter per requester.
  - A counter increments on each gnt pulse for its requester and saturates at 255.
  - Counters clear on rst.
  - Adds input stats_clr (1 bit), which zeroes all counters synchronously; stats_clr wins over a simultaneous increment.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package op_share_pkg:
  - enum op_e {OP_AND, OP_OR, OP_XOR, OP_ADD} (2-bit).
  - enum arb_state_e {IDLE, EXEC, RESP}.
  - struct op_req_t {op_e op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b;}.
  - Constant default width 2.
- Sub-module rr_pick: combinational round-robin selector; inputs req and last, outputs one-hot pick and index. Used once.
- The compute function lives in the package as a function, not a module.

Test Plan:
- Reset, then req=001, opcode0=11, a0=2'b11, b0=2'b01 → gnt=001 for 1 cycle; 2 cycles later res_valid=1, res_data=3'b100, res_id=0.
- req=111 held, all opcode 00, res_ready=1 → grant order 0,1,2,0,1,2 with exactly 3 cycles between gnt pulses.
- res_ready held 0 for 5 cycles in RESP with req=010 pending → res_data/res_id stable, no gnt issued; gnt=010 in the first IDLE cycle after the handshake.
- req1 (opcode 10, a=2'b10, b=2'b11) changes its operands to 0 the cycle after gnt → res_data=3'b001.
- rst pulsed during EXEC of requester 2 → next cycle res_valid=0, busy=0; with req=111 the next gnt=001.
- With OP_SHARE_ARB_STATS_EN: 300 grants to requester 0 → its grant_cnt field reads 255; stats_clr asserted together with a gnt → field reads 0.
